// File: rtl/ov7670_capture.sv
// OV7670 capture front end: turns the camera's RGB444 byte stream into
// 12-bit pixel writes for a linear frame buffer, with optional 2:1
// decimation on both axes, overflow detection and an end-of-frame pulse.
//
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   IDLE       | capture disabled, waiting for ENABLE_I
//   WAIT_FRAME | armed, waiting for the VSYNC falling edge that opens a frame
//   CAPTURE    | frame in progress, assembling and writing pixels
module ov7670_capture #(
    parameter int IMG_W    = 160,
    parameter int IMG_H    = 120,
    parameter int DECIM_EN = 1
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        ENABLE_I,
    input  logic        CAM_VSYNC_I,
    input  logic        CAM_HREF_I,
    input  logic [7:0]  CAM_DATA_I,
    output logic        WR_EN_O,
    output logic [15:0] WR_ADDR_O,
    output logic [11:0] WR_DATA_O,
    output logic        FRAME_DONE_O,
    output logic        OVERFLOW_O
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2
    } state_t;

    localparam logic [16:0] DEPTH = 17'(IMG_W * IMG_H);
    localparam logic        DECIM = (DECIM_EN != 0);

    state_t      state;
    state_t      state_nxt;

    logic        vsync_q;
    logic        vsync_qq;
    logic        href_q;
    logic        href_qq;
    logic [7:0]  data_q;

    logic        phase;
    logic [3:0]  red;
    // Only the parity of the pixel and line indices decides decimation,
    // so the indices are kept modulo 2.
    logic        pix_odd;
    logic        line_odd;
    logic [16:0] wr_count;
    logic        done_pend;

    logic        vsync_rise;
    logic        vsync_fall;
    logic        href_rise;
    logic        href_fall;
    logic        in_capture;
    logic        frame_start;
    logic        frame_end;
    logic        pix_done;
    logic        pix_keep;
    logic        room;

    assign vsync_rise  = vsync_q & ~vsync_qq;
    assign vsync_fall  = ~vsync_q & vsync_qq;
    assign href_rise   = href_q & ~href_qq;
    assign href_fall   = ~href_q & href_qq;
    assign in_capture  = (state == CAPTURE);
    assign frame_start = (state == WAIT_FRAME) & vsync_fall;
    assign frame_end   = in_capture & vsync_rise;
    assign pix_done    = in_capture & href_q & phase;
    assign pix_keep    = pix_done & (~DECIM | (~pix_odd & ~line_odd));
    assign room        = (wr_count < DEPTH);

    // State register
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; ENABLE_I only matters at frame boundaries
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (ENABLE_I) state_nxt = WAIT_FRAME;
            end
            WAIT_FRAME: begin
                if (vsync_fall) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                if (vsync_rise) state_nxt = ENABLE_I ? WAIT_FRAME : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Single register stage on the camera inputs, plus one history stage for edges
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            vsync_q  <= 1'b0;
            vsync_qq <= 1'b0;
            href_q   <= 1'b0;
            href_qq  <= 1'b0;
            data_q   <= '0;
        end else begin
            vsync_q  <= CAM_VSYNC_I;
            vsync_qq <= vsync_q;
            href_q   <= CAM_HREF_I;
            href_qq  <= href_q;
            data_q   <= CAM_DATA_I;
        end
    end

    // Byte phase, red nibble latch and pixel/line parity tracking
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            phase    <= 1'b0;
            red      <= '0;
            pix_odd  <= 1'b0;
            line_odd <= 1'b0;
        end else begin
            // Phase drops to 0 whenever HREF is low, so a dangling odd byte is lost.
            if (in_capture && href_q) begin
                phase <= ~phase;
                if (!phase) red <= data_q[3:0];
            end else begin
                phase <= 1'b0;
            end

            if (href_rise) begin
                pix_odd <= 1'b0;
            end else if (pix_done) begin
                pix_odd <= ~pix_odd;
            end

            if (frame_start) begin
                line_odd <= 1'b0;
            end else if (in_capture && href_fall) begin
                line_odd <= ~line_odd;
            end
        end
    end

    // Write port, overflow flag and end-of-frame pulse
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            WR_EN_O      <= 1'b0;
            WR_ADDR_O    <= '0;
            WR_DATA_O    <= '0;
            FRAME_DONE_O <= 1'b0;
            OVERFLOW_O   <= 1'b0;
            wr_count     <= '0;
            done_pend    <= 1'b0;
        end else begin
            WR_EN_O <= 1'b0;
            // A pixel finishing on the closing edge is written first; the
            // done pulse then slips one cycle so it follows that write.
            FRAME_DONE_O <= (frame_end & ~pix_done) | done_pend;
            done_pend    <= frame_end & pix_done;

            if (pix_keep) begin
                if (room) begin
                    WR_EN_O   <= 1'b1;
                    WR_ADDR_O <= wr_count[15:0];
                    WR_DATA_O <= {red, data_q};
                    wr_count  <= wr_count + 17'd1;
                end else begin
                    OVERFLOW_O <= 1'b1;
                end
            end

            if (frame_start) begin
                wr_count   <= '0;
                OVERFLOW_O <= 1'b0;
            end

            if (frame_end) begin
                wr_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// Bench for ov7670_capture: two instances (decimating and non-decimating,
// reduced frame sizes) share the camera stimulus; a pixel-level model in
// the bench predicts the write stream of each.
module tb_ov7670_capture;

    localparam int BW    = 20;
    localparam int BH    = 12;
    localparam int SW    = 4;
    localparam int SH    = 2;
    localparam int CAP_B = BW * BH;
    localparam int CAP_S = SW * SH;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        vsync;
    logic        href;
    logic [7:0]  data;

    logic        b_wr_en, s_wr_en;
    logic [15:0] b_wr_addr, s_wr_addr;
    logic [11:0] b_wr_data, s_wr_data;
    logic        b_done, s_done;
    logic        b_ovf, s_ovf;

    ov7670_capture #(.IMG_W(BW), .IMG_H(BH), .DECIM_EN(1)) dut_big (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(enable),
        .CAM_VSYNC_I(vsync), .CAM_HREF_I(href), .CAM_DATA_I(data),
        .WR_EN_O(b_wr_en), .WR_ADDR_O(b_wr_addr), .WR_DATA_O(b_wr_data),
        .FRAME_DONE_O(b_done), .OVERFLOW_O(b_ovf)
    );

    ov7670_capture #(.IMG_W(SW), .IMG_H(SH), .DECIM_EN(0)) dut_small (
        .CLK_I(clk), .RST_I(rst), .ENABLE_I(enable),
        .CAM_VSYNC_I(vsync), .CAM_HREF_I(href), .CAM_DATA_I(data),
        .WR_EN_O(s_wr_en), .WR_ADDR_O(s_wr_addr), .WR_DATA_O(s_wr_data),
        .FRAME_DONE_O(s_done), .OVERFLOW_O(s_ovf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [15:0] b_act_addr[$], s_act_addr[$], b_exp_addr[$], s_exp_addr[$];
    logic [11:0] b_act_data[$], s_act_data[$], b_exp_data[$], s_exp_data[$];
    int b_done_cnt, s_done_cnt, b_wr_cyc, b_done_cyc;

    int b_n, s_n;
    bit b_ovf_m, s_ovf_m;
    logic [7:0] lb[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Observe write port and done pulses away from the active edge
    always @(negedge clk) begin
        if (b_wr_en) begin
            b_act_addr.push_back(b_wr_addr);
            b_act_data.push_back(b_wr_data);
            b_wr_cyc = cyc;
        end
        if (b_done) begin
            b_done_cnt++;
            b_done_cyc = cyc;
        end
        if (s_wr_en) begin
            s_act_addr.push_back(s_wr_addr);
            s_act_data.push_back(s_wr_data);
        end
        if (s_done) s_done_cnt++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_obs;
        b_act_addr.delete(); b_act_data.delete(); s_act_addr.delete(); s_act_data.delete();
        b_exp_addr.delete(); b_exp_data.delete(); s_exp_addr.delete(); s_exp_data.delete();
        b_done_cnt = 0; s_done_cnt = 0; b_wr_cyc = -1; b_done_cyc = -1;
    endtask

    // Reference: each byte pair of a line is one pixel; keep rules per instance,
    // addresses are the running count of writes, capacity-limited.
    task automatic model_line(input int l, input bit cap);
        if (!cap) return;
        for (int k = 0; k < lb.size() / 2; k++) begin
            logic [11:0] px;
            px = {lb[2*k][3:0], lb[2*k+1]};
            if ((k % 2 == 0) && (l % 2 == 0)) begin
                if (b_n < CAP_B) begin
                    b_exp_addr.push_back(16'(b_n));
                    b_exp_data.push_back(px);
                    b_n++;
                end else begin
                    b_ovf_m = 1'b1;
                end
            end
            if (s_n < CAP_S) begin
                s_exp_addr.push_back(16'(s_n));
                s_exp_data.push_back(px);
                s_n++;
            end else begin
                s_ovf_m = 1'b1;
            end
        end
    endtask

    // One camera frame: blanking, lines of nbytes, closing VSYNC.
    task automatic drive_frame(input int nlines, input int nbytes, input bit cap,
                               input int drop_line, input bit vs_last, input bit abc);
        clear_obs();
        if (cap) begin
            b_n = 0; s_n = 0; b_ovf_m = 1'b0; s_ovf_m = 1'b0;
        end
        vsync = 1'b1;
        repeat (6) tick();
        vsync = 1'b0;
        repeat (6) tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == drop_line) enable = 1'b0;
            lb.delete();
            href = 1'b1;
            for (int i = 0; i < nbytes; i++) begin
                data = abc ? ((i % 2 == 1) ? 8'hBC : 8'h0A) : 8'($urandom);
                lb.push_back(data);
                if (vs_last && l == nlines - 1 && i == nbytes - 1) vsync = 1'b1;
                tick();
            end
            href = 1'b0;
            data = 8'h00;
            model_line(l, cap);
            repeat (4) tick();
        end
        vsync = 1'b1;
        repeat (8) tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; enable = 1'b0; vsync = 1'b1; href = 1'b0; data = 8'h00;
        b_ovf_m = 1'b0; s_ovf_m = 1'b0;
        repeat (3) tick();
        href = 1'b1; data = 8'hA5;
        repeat (2) tick();
        n_checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data, b_done, b_ovf} !== 30'd0) begin
            n_errors++;
            $display("FAIL reset_big: got %h want 0", {b_wr_en, b_wr_addr, b_wr_data, b_done, b_ovf});
        end
        n_checks++;
        if ({s_wr_en, s_wr_addr, s_wr_data, s_done, s_ovf} !== 30'd0) begin
            n_errors++;
            $display("FAIL reset_small: got %h want 0", {s_wr_en, s_wr_addr, s_wr_data, s_done, s_ovf});
        end
        href = 1'b0; data = 8'h00;
        rst = 1'b0;
        enable = 1'b1;
        repeat (2) tick();
    endtask

    task automatic test_full_frame;
        drive_frame(24, 80, 1'b1, -1, 1'b0, 1'b1);
        n_checks++;
        if (b_act_addr.size() !== CAP_B) begin
            n_errors++;
            $display("FAIL full_count: got %0d want %0d", b_act_addr.size(), CAP_B);
        end
        for (int i = 0; i < b_act_addr.size(); i++) begin
            n_checks++;
            if (b_act_addr[i] !== 16'(i) || b_act_data[i] !== 12'hABC) begin
                n_errors++;
                $display("FAIL full_write[%0d]: got addr %0d data %h want addr %0d data abc",
                         i, b_act_addr[i], b_act_data[i], i);
            end
        end
        n_checks++;
        if (b_done_cnt !== 1 || b_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL full_done: got done %0d ovf %b want done 1 ovf 0", b_done_cnt, b_ovf);
        end
    endtask

    task automatic test_overflow;
        drive_frame(3, 10, 1'b1, -1, 1'b0, 1'b0);
        n_checks++;
        if (s_act_addr.size() !== 8 || s_ovf !== 1'b1 || s_ovf_m !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_small: got writes %0d ovf %b want writes 8 ovf 1", s_act_addr.size(), s_ovf);
        end
        for (int i = 0; i < s_act_addr.size() && i < s_exp_addr.size(); i++) begin
            n_checks++;
            if (s_act_addr[i] !== s_exp_addr[i] || s_act_data[i] !== s_exp_data[i] || s_act_addr[i] > 16'd7) begin
                n_errors++;
                $display("FAIL ovf_write[%0d]: got %0d/%h want %0d/%h", i,
                         s_act_addr[i], s_act_data[i], s_exp_addr[i], s_exp_data[i]);
            end
        end
        n_checks++;
        if (b_act_addr.size() !== 6 || b_ovf !== 1'b0 || s_done_cnt !== 1) begin
            n_errors++;
            $display("FAIL ovf_big: got writes %0d ovf %b sdone %0d want 6 0 1",
                     b_act_addr.size(), b_ovf, s_done_cnt);
        end
    endtask

    task automatic test_odd_bytes;
        drive_frame(2, 7, 1'b1, -1, 1'b0, 1'b0);
        n_checks++;
        if (s_act_addr.size() !== 6 || s_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL odd_count: got writes %0d ovf %b want 6 0", s_act_addr.size(), s_ovf);
        end
        for (int i = 0; i < s_act_addr.size() && i < s_exp_addr.size(); i++) begin
            n_checks++;
            if (s_act_addr[i] !== s_exp_addr[i] || s_act_data[i] !== s_exp_data[i]) begin
                n_errors++;
                $display("FAIL odd_write[%0d]: got %0d/%h want %0d/%h", i,
                         s_act_addr[i], s_act_data[i], s_exp_addr[i], s_exp_data[i]);
            end
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 4; f++) begin
            drive_frame($urandom_range(2, 26), $urandom_range(2, 90), 1'b1, -1, 1'b0, 1'b0);
            n_checks++;
            if (b_act_addr.size() !== b_exp_addr.size() || s_act_addr.size() !== s_exp_addr.size()) begin
                n_errors++;
                $display("FAIL rand_count f%0d: got %0d/%0d want %0d/%0d", f,
                         b_act_addr.size(), s_act_addr.size(), b_exp_addr.size(), s_exp_addr.size());
            end
            for (int i = 0; i < b_act_addr.size() && i < b_exp_addr.size(); i++) begin
                n_checks++;
                if (b_act_addr[i] !== b_exp_addr[i] || b_act_data[i] !== b_exp_data[i]) begin
                    n_errors++;
                    $display("FAIL rand_big f%0d[%0d]: got %0d/%h want %0d/%h", f, i,
                             b_act_addr[i], b_act_data[i], b_exp_addr[i], b_exp_data[i]);
                end
            end
            for (int i = 0; i < s_act_addr.size() && i < s_exp_addr.size(); i++) begin
                n_checks++;
                if (s_act_addr[i] !== s_exp_addr[i] || s_act_data[i] !== s_exp_data[i]) begin
                    n_errors++;
                    $display("FAIL rand_small f%0d[%0d]: got %0d/%h want %0d/%h", f, i,
                             s_act_addr[i], s_act_data[i], s_exp_addr[i], s_exp_data[i]);
                end
            end
            n_checks++;
            if (b_ovf !== b_ovf_m || s_ovf !== s_ovf_m || b_done_cnt !== 1 || s_done_cnt !== 1) begin
                n_errors++;
                $display("FAIL rand_flags f%0d: got ovf %b/%b done %0d/%0d want ovf %b/%b done 1/1", f,
                         b_ovf, s_ovf, b_done_cnt, s_done_cnt, b_ovf_m, s_ovf_m);
            end
        end
    endtask

    task automatic test_enable_drop;
        drive_frame(8, 24, 1'b1, 4, 1'b0, 1'b0);
        n_checks++;
        if (b_act_addr.size() !== b_exp_addr.size() || s_act_addr.size() !== s_exp_addr.size()
            || b_done_cnt !== 1 || s_done_cnt !== 1) begin
            n_errors++;
            $display("FAIL drop_frame: got writes %0d/%0d done %0d/%0d want %0d/%0d done 1/1",
                     b_act_addr.size(), s_act_addr.size(), b_done_cnt, s_done_cnt,
                     b_exp_addr.size(), s_exp_addr.size());
        end
        drive_frame(6, 24, 1'b0, -1, 1'b0, 1'b0);
        n_checks++;
        if (b_act_addr.size() !== 0 || s_act_addr.size() !== 0 || b_done_cnt !== 0 || s_done_cnt !== 0) begin
            n_errors++;
            $display("FAIL drop_idle: got writes %0d/%0d done %0d/%0d want 0/0 done 0/0",
                     b_act_addr.size(), s_act_addr.size(), b_done_cnt, s_done_cnt);
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid_line;
        clear_obs();
        vsync = 1'b1;
        repeat (6) tick();
        vsync = 1'b0;
        repeat (6) tick();
        href = 1'b1;
        for (int i = 0; i < 12; i++) begin
            data = 8'($urandom);
            tick();
        end
        n_checks++;
        if (b_wr_addr !== 16'd2) begin
            n_errors++;
            $display("FAIL midrst_pre_addr: got %0d want 2", b_wr_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({b_wr_en, b_wr_addr, b_wr_data, b_done, b_ovf, s_wr_en, s_wr_addr, s_wr_data, s_done, s_ovf} !== 60'd0) begin
            n_errors++;
            $display("FAIL midrst_async: got big %h small %h want 0",
                     {b_wr_en, b_wr_addr, b_wr_data, b_done, b_ovf}, {s_wr_en, s_wr_addr, s_wr_data, s_done, s_ovf});
        end
        b_ovf_m = 1'b0; s_ovf_m = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        clear_obs();
        for (int i = 0; i < 6; i++) begin
            data = 8'($urandom);
            tick();
        end
        href = 1'b0;
        repeat (4) tick();
        for (int l = 0; l < 2; l++) begin
            href = 1'b1;
            for (int i = 0; i < 10; i++) begin
                data = 8'($urandom);
                tick();
            end
            href = 1'b0;
            repeat (4) tick();
        end
        vsync = 1'b1;
        repeat (8) tick();
        n_checks++;
        if (b_act_addr.size() !== 0 || s_act_addr.size() !== 0 || b_done_cnt !== 0 || s_done_cnt !== 0) begin
            n_errors++;
            $display("FAIL midrst_quiet: got writes %0d/%0d done %0d/%0d want all 0",
                     b_act_addr.size(), s_act_addr.size(), b_done_cnt, s_done_cnt);
        end
        drive_frame(4, 20, 1'b1, -1, 1'b0, 1'b0);
        n_checks++;
        if (b_act_addr.size() == 0 || b_act_addr[0] !== 16'd0 || s_act_addr.size() == 0 || s_act_addr[0] !== 16'd0
            || b_act_data[0] !== b_exp_data[0] || s_act_data[0] !== s_exp_data[0]) begin
            n_errors++;
            $display("FAIL midrst_first: got %0d/%0d writes, first big addr %0d want 0",
                     b_act_addr.size(), s_act_addr.size(), (b_act_addr.size() > 0) ? b_act_addr[0] : 16'hFFFF);
        end
    endtask

    task automatic test_last_pixel_at_vsync;
        drive_frame(23, 78, 1'b1, -1, 1'b1, 1'b0);
        n_checks++;
        if (b_act_addr.size() !== CAP_B || b_act_addr[b_act_addr.size()-1] !== 16'(CAP_B - 1)) begin
            n_errors++;
            $display("FAIL lastpix_addr: got %0d writes, last addr %0d want %0d writes last %0d",
                     b_act_addr.size(), (b_act_addr.size() > 0) ? b_act_addr[b_act_addr.size()-1] : 16'hFFFF,
                     CAP_B, CAP_B - 1);
        end
        n_checks++;
        if (b_act_data.size() == 0 || b_exp_data.size() == 0
            || b_act_data[b_act_data.size()-1] !== b_exp_data[b_exp_data.size()-1]) begin
            n_errors++;
            $display("FAIL lastpix_data: last write data mismatch vs model");
        end
        n_checks++;
        if (b_done_cnt !== 1 || b_done_cyc !== b_wr_cyc + 1 || b_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL lastpix_done: got done %0d at cyc %0d, last write cyc %0d, ovf %b want 1 at %0d ovf 0",
                     b_done_cnt, b_done_cyc, b_wr_cyc, b_ovf, b_wr_cyc + 1);
        end
        n_checks++;
        if (s_act_addr.size() !== CAP_S || s_ovf !== 1'b1 || s_done_cnt !== 1) begin
            n_errors++;
            $display("FAIL lastpix_small: got writes %0d ovf %b done %0d want 8 1 1",
                     s_act_addr.size(), s_ovf, s_done_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_overflow();
        test_odd_bytes();
        test_random_frames();
        test_enable_drop();
        test_reset_mid_line();
        test_last_pixel_at_vsync();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
